// File: rtl/queue_rr_arbiter_pkg.sv
// Shared types and constants for the queue round-robin arbiter and its helpers.
package queue_rr_arbiter_pkg;

  localparam int unsigned ValidWidth = 1;
  localparam int unsigned AckWidth   = 1;

  // Output slot occupancy; the encoding doubles as request_valid_out.
  typedef enum logic {
    SlotEmpty = 1'b0,
    SlotFull  = 1'b1
  } slot_state_e;

  function automatic int unsigned id_width(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority select: first set bit of req_mask at or after base_ptr, wrapping.
module rr_priority_select #(
  parameter int unsigned NUM_REQUESTERS    = 4,
  parameter int unsigned IDX_WIDTH_IN_BITS = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0]    req_mask,
  input  logic [IDX_WIDTH_IN_BITS-1:0] base_ptr,
  output logic [NUM_REQUESTERS-1:0]    grant_onehot,
  output logic [IDX_WIDTH_IN_BITS-1:0] grant_idx,
  output logic                         found,
  output logic                         single
);

  logic [NUM_REQUESTERS-1:0]    rotated;
  logic [IDX_WIDTH_IN_BITS-1:0] offset;

  always_comb begin
    // Doubling the mask turns the circular scan into a plain shift.
    rotated = NUM_REQUESTERS'({req_mask, req_mask} >> base_ptr);
    offset  = '0;
    for (int i = int'(NUM_REQUESTERS) - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IDX_WIDTH_IN_BITS'(i);
    end
    // Power-of-two requester count makes the index add wrap for free.
    grant_idx    = base_ptr + offset;
    found        = |req_mask;
    single       = found && ((req_mask & (req_mask - NUM_REQUESTERS'(1))) == '0);
    grant_onehot = found ? (NUM_REQUESTERS'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/queue_rr_arbiter.sv
// Shares one downstream consumer among several upstream queues with round-robin
// arbitration, a bounded burst lock and a single registered output slot.
module queue_rr_arbiter
  import queue_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS             = 4,
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int unsigned REQUESTER_ID_WIDTH_IN_BITS = id_width(NUM_REQUESTERS),
  parameter int unsigned MAX_BURST_LEN              = 4,
  parameter int unsigned BURST_CNT_WIDTH_IN_BITS    = $clog2(MAX_BURST_LEN + 1)
) (
  input  logic                                                 clk_in,
  input  logic                                                 reset_in,
  input  logic [NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
  input  logic [NUM_REQUESTERS-1:0]                            request_valid_packed_in,
  output logic [NUM_REQUESTERS-1:0]                            issue_ack_packed_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                request_out,
  output logic [REQUESTER_ID_WIDTH_IN_BITS-1:0]                request_id_out,
  output logic                                                 request_valid_out,
  input  logic                                                 issue_ack_in
);

  localparam int unsigned W    = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int unsigned IdW  = REQUESTER_ID_WIDTH_IN_BITS;
  localparam int unsigned CntW = BURST_CNT_WIDTH_IN_BITS;
  localparam logic [CntW-1:0] BurstMax = CntW'(MAX_BURST_LEN);

  slot_state_e         slot_q, slot_d;
  logic [W-1:0]        data_q, data_d;
  logic [IdW-1:0]      id_q, id_d;
  logic [IdW-1:0]      last_ptr_q, last_ptr_d;
  logic [CntW-1:0]     burst_cnt_q, burst_cnt_d;

  logic                      slot_free;
  logic                      lock;
  logic                      grant;
  logic [IdW-1:0]            scan_base;
  logic [IdW-1:0]            winner;
  logic [NUM_REQUESTERS-1:0] sel_onehot;
  logic [IdW-1:0]            sel_idx;
  logic                      sel_found;
  logic                      sel_single;

  assign scan_base = last_ptr_q + IdW'(1);

  rr_priority_select #(
    .NUM_REQUESTERS    (NUM_REQUESTERS),
    .IDX_WIDTH_IN_BITS (IdW)
  ) u_select (
    .req_mask     (request_valid_packed_in),
    .base_ptr     (scan_base),
    .grant_onehot (sel_onehot),
    .grant_idx    (sel_idx),
    .found        (sel_found),
    .single       (sel_single)
  );

  always_comb begin
    slot_free = (slot_q == SlotEmpty) | issue_ack_in;
    // A zero count means no burst is in progress, so after reset requester 0 wins first.
    lock = (burst_cnt_q != '0) && (burst_cnt_q < BurstMax) &&
           request_valid_packed_in[last_ptr_q] && !sel_single;
    grant  = slot_free && sel_found && !reset_in;
    winner = lock ? last_ptr_q : sel_idx;

    issue_ack_packed_out = '0;
    if (grant) begin
      issue_ack_packed_out = lock ? (NUM_REQUESTERS'(1) << last_ptr_q) : sel_onehot;
    end

    slot_d      = slot_q;
    data_d      = data_q;
    id_d        = id_q;
    last_ptr_d  = last_ptr_q;
    burst_cnt_d = burst_cnt_q;

    unique case (slot_q)
      SlotEmpty: begin
        if (grant) slot_d = SlotFull;
      end
      SlotFull: begin
        if (!grant && issue_ack_in) slot_d = SlotEmpty;
      end
      default: slot_d = SlotEmpty;
    endcase

    if (grant) begin
      data_d = request_packed_in[winner*W +: W];
      id_d   = winner;
      if (winner == last_ptr_q) begin
        burst_cnt_d = (burst_cnt_q == BurstMax) ? burst_cnt_q : burst_cnt_q + CntW'(1);
      end else begin
        burst_cnt_d = CntW'(1);
        last_ptr_d  = winner;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      slot_q      <= SlotEmpty;
      data_q      <= '0;
      id_q        <= '0;
      last_ptr_q  <= IdW'(NUM_REQUESTERS - 1);
      burst_cnt_q <= '0;
    end else begin
      slot_q      <= slot_d;
      data_q      <= data_d;
      id_q        <= id_d;
      last_ptr_q  <= last_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign request_out       = data_q;
  assign request_id_out    = id_q;
  assign request_valid_out = (slot_q == SlotFull);

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Directed bench for queue_rr_arbiter: one instance with burst length 4, one with 1.
module tb_queue_rr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 64;

  logic           clk;
  logic           reset_in;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic           issue_ack;

  logic [N-1:0]   ack_a, ack_b;
  logic [W-1:0]   out_a, out_b;
  logic [1:0]     id_a, id_b;
  logic           vld_a, vld_b;

  int total = 0;
  int bad   = 0;

  queue_rr_arbiter #(
    .NUM_REQUESTERS             (N),
    .SINGLE_ENTRY_WIDTH_IN_BITS (W),
    .MAX_BURST_LEN              (4)
  ) dut (
    .clk_in                  (clk),
    .reset_in                (reset_in),
    .request_packed_in       (req_data),
    .request_valid_packed_in (req_valid),
    .issue_ack_packed_out    (ack_a),
    .request_out             (out_a),
    .request_id_out          (id_a),
    .request_valid_out       (vld_a),
    .issue_ack_in            (issue_ack)
  );

  queue_rr_arbiter #(
    .NUM_REQUESTERS             (N),
    .SINGLE_ENTRY_WIDTH_IN_BITS (W),
    .MAX_BURST_LEN              (1)
  ) dut_b1 (
    .clk_in                  (clk),
    .reset_in                (reset_in),
    .request_packed_in       (req_data),
    .request_valid_packed_in (req_valid),
    .issue_ack_packed_out    (ack_b),
    .request_out             (out_b),
    .request_id_out          (id_b),
    .request_valid_out       (vld_b),
    .issue_ack_in            (issue_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_in  = 1'b1;
    req_valid = '0;
    issue_ack = 1'b0;
    tick();
    reset_in  = 1'b0;
  endtask

  task automatic test_reset;
    reset_in  = 1'b1;
    req_valid = '0;
    issue_ack = 1'b0;
    req_data  = '0;
    tick();
    tick();
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", vld_a); end
    total++; if (out_a !== 64'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_a); end
    total++; if (id_a !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", id_a); end
    req_valid = 4'hF;
    #1;
    total++; if (ack_a !== 4'b0000) begin bad++; $display("FAIL reset_ack_a got=%b want=0000", ack_a); end
    total++; if (ack_b !== 4'b0000) begin bad++; $display("FAIL reset_ack_b got=%b want=0000", ack_b); end
    reset_in  = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single_stream;
    logic [W-1:0] exp_data;
    do_reset();
    issue_ack = 1'b1;
    req_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      exp_data = 64'hA0 + 64'(k);
      req_data[2*W +: W] = exp_data;
      #1;
      total++; if (ack_a !== 4'b0100) begin bad++; $display("FAIL stream_ack[%0d] got=%b want=0100", k, ack_a); end
      tick();
      total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", k, vld_a); end
      total++; if (out_a !== exp_data) begin bad++; $display("FAIL stream_data[%0d] got=%h want=%h", k, out_a, exp_data); end
      total++; if (id_a !== 2'd2) begin bad++; $display("FAIL stream_id[%0d] got=%0d want=2", k, id_a); end
    end
    req_valid = '0;
    tick();
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", vld_a); end
  endtask

  task automatic test_rr_and_burst;
    logic [1:0] exp_a, exp_b;
    logic [N-1:0] exp_ack_a, exp_ack_b;
    do_reset();
    for (int i = 0; i < int'(N); i++) req_data[i*W +: W] = 64'h10 + 64'(i);
    issue_ack = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 20; k++) begin
      exp_a     = 2'((k / 4) % 4);
      exp_b     = 2'(k % 4);
      exp_ack_a = 4'b0001 << exp_a;
      exp_ack_b = 4'b0001 << exp_b;
      #1;
      total++; if (ack_a !== exp_ack_a) begin bad++; $display("FAIL burst_ack[%0d] got=%b want=%b", k, ack_a, exp_ack_a); end
      total++; if (ack_b !== exp_ack_b) begin bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", k, ack_b, exp_ack_b); end
      tick();
      total++; if (id_a !== exp_a) begin bad++; $display("FAIL burst_id[%0d] got=%0d want=%0d", k, id_a, exp_a); end
      total++; if (out_a !== 64'h10 + 64'(exp_a)) begin bad++; $display("FAIL burst_data[%0d] got=%h want=%h", k, out_a, 64'h10 + 64'(exp_a)); end
      total++; if (id_b !== exp_b) begin bad++; $display("FAIL rr_id[%0d] got=%0d want=%0d", k, id_b, exp_b); end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    issue_ack = 1'b0;
    req_valid = 4'b0010;
    req_data[1*W +: W] = 64'h55;
    #1;
    total++; if (ack_a !== 4'b0010) begin bad++; $display("FAIL bp_load_ack got=%b want=0010", ack_a); end
    tick();
    req_valid = 4'b1000;
    req_data[3*W +: W] = 64'h77;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (ack_a !== 4'b0000) begin bad++; $display("FAIL bp_hold_ack[%0d] got=%b want=0000", k, ack_a); end
      total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", k, vld_a); end
      total++; if (out_a !== 64'h55) begin bad++; $display("FAIL bp_hold_data[%0d] got=%h want=55", k, out_a); end
      total++; if (id_a !== 2'd1) begin bad++; $display("FAIL bp_hold_id[%0d] got=%0d want=1", k, id_a); end
      tick();
    end
    issue_ack = 1'b1;
    #1;
    total++; if (ack_a !== 4'b1000) begin bad++; $display("FAIL bp_release_ack got=%b want=1000", ack_a); end
    tick();
    total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b want=1", vld_a); end
    total++; if (out_a !== 64'h77) begin bad++; $display("FAIL bp_next_data got=%h want=77", out_a); end
    total++; if (id_a !== 2'd3) begin bad++; $display("FAIL bp_next_id got=%0d want=3", id_a); end
    req_valid = '0;
    tick();
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", vld_a); end
    tick();
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL bp_empty_ack_valid got=%b want=0", vld_a); end
    total++; if (ack_a !== 4'b0000) begin bad++; $display("FAIL bp_empty_ack got=%b want=0000", ack_a); end
  endtask

  task automatic test_wrap;
    do_reset();
    issue_ack = 1'b1;
    req_valid = 4'b1000;
    for (int k = 0; k < 4; k++) tick();
    total++; if (id_a !== 2'd3) begin bad++; $display("FAIL wrap_pre_id got=%0d want=3", id_a); end
    req_valid = 4'b1001;
    #1;
    total++; if (ack_a !== 4'b0001) begin bad++; $display("FAIL wrap_ack_a got=%b want=0001", ack_a); end
    total++; if (ack_b !== 4'b0001) begin bad++; $display("FAIL wrap_ack_b got=%b want=0001", ack_b); end
    tick();
    total++; if (id_a !== 2'd0) begin bad++; $display("FAIL wrap_id got=%0d want=0", id_a); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid;
    do_reset();
    issue_ack = 1'b0;
    req_valid = 4'b0100;
    req_data[2*W +: W] = 64'hC2;
    tick();
    total++; if (id_a !== 2'd2) begin bad++; $display("FAIL midrst_pre_id got=%0d want=2", id_a); end
    reset_in  = 1'b1;
    req_valid = 4'hF;
    #1;
    total++; if (ack_a !== 4'b0000) begin bad++; $display("FAIL midrst_ack got=%b want=0000", ack_a); end
    tick();
    total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", vld_a); end
    total++; if (out_a !== 64'h0) begin bad++; $display("FAIL midrst_data got=%h want=0", out_a); end
    reset_in  = 1'b0;
    issue_ack = 1'b1;
    #1;
    total++; if (ack_a !== 4'b0001) begin bad++; $display("FAIL midrst_first_ack got=%b want=0001", ack_a); end
    tick();
    total++; if (id_a !== 2'd0) begin bad++; $display("FAIL midrst_first_id got=%0d want=0", id_a); end
    total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL midrst_first_valid got=%b want=1", vld_a); end
  endtask

  initial begin
    reset_in  = 1'b1;
    req_valid = '0;
    issue_ack = 1'b0;
    req_data  = '0;
    test_reset();
    test_single_stream();
    test_rr_and_burst();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
